// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// the sequencer state type and small op-decode helpers.
package muldiv_iter_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_t;

  // Bit 1 selects divide, bit 0 selects signed operands.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, record the quotient bit.
module muldiv_iter_div_step
  import muldiv_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] rem_shift;
  logic            fits;

  // quo_in carries the not-yet-consumed dividend bits at its top and collects
  // quotient bits at its bottom, so after DATA_W steps it is the quotient.
  assign rem_shift = {rem_in, quo_in[DATA_W-1]};
  assign fits      = rem_shift >= {1'b0, divisor};
  assign rem_out   = fits ? (rem_shift[DATA_W-1:0] - divisor) : rem_shift[DATA_W-1:0];
  assign quo_out   = {quo_in[DATA_W-2:0], fits};

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage with annul, divide-by-zero
// early-out and a stall handshake; returns {hi,lo} for HI/LO writeback.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic                  stallreq_o,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   result_o
);

  localparam int MUL_STEPS = DATA_W / MUL_BITS;
  localparam int CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

  md_state_t             state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [2*DATA_W-1:0]   mcand_reg;
  logic [DATA_W-1:0]     mplier_reg;
  logic [2*DATA_W-1:0]   acc_reg;
  logic [DATA_W-1:0]     rem_reg;
  logic [DATA_W-1:0]     quo_reg;
  logic [DATA_W-1:0]     divisor_reg;
  logic [DATA_W-1:0]     dividend_reg;
  logic                  neg_res_reg;
  logic                  neg_rem_reg;
  logic                  is_div_reg;
  logic                  dz_reg;
  logic [2*DATA_W-1:0]   result_reg;

  logic                  accept;
  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [2*DATA_W-1:0]   partial;
  logic [DATA_W-1:0]     rem_step, quo_step;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quo_fix, rem_fix;
  logic [2*DATA_W-1:0]   fixed;

  assign accept = (state_reg == ST_IDLE) & start_i & ~annul_i;

  // Sequencing runs on magnitudes; signs are re-applied once in DONE.
  assign a_neg = op_is_signed(op_i) & opdata1_i[DATA_W-1];
  assign b_neg = op_is_signed(op_i) & opdata2_i[DATA_W-1];
  assign a_mag = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag = b_neg ? -opdata2_i : opdata2_i;

  assign partial = mcand_reg * (2*DATA_W)'(mplier_reg[MUL_BITS-1:0]);

  muldiv_iter_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (divisor_reg),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
  assign quo_fix  = neg_res_reg ? -quo_reg : quo_reg;
  assign rem_fix  = neg_rem_reg ? -rem_reg : rem_reg;
  assign fixed    = dz_reg     ? {dividend_reg, {DATA_W{1'b1}}} :
                    is_div_reg ? {rem_fix, quo_fix} : prod_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      divisor_reg  <= '0;
      dividend_reg <= '0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      is_div_reg   <= 1'b0;
      dz_reg       <= 1'b0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            cnt_reg      <= '0;
            mcand_reg    <= (2*DATA_W)'(a_mag);
            mplier_reg   <= b_mag;
            acc_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= a_mag;
            divisor_reg  <= b_mag;
            dividend_reg <= opdata1_i;
            neg_res_reg  <= a_neg ^ b_neg;
            neg_rem_reg  <= a_neg;
            is_div_reg   <= op_is_div(op_i);
            dz_reg       <= op_is_div(op_i) & (opdata2_i == '0);
            if (!op_is_div(op_i))
              state_reg <= ST_MUL;
            else if (opdata2_i == '0)
              state_reg <= ST_DONE;
            else
              state_reg <= ST_DIV;
          end
        end
        ST_MUL: begin
          if (annul_i) begin
            state_reg <= ST_IDLE;
          end else begin
            acc_reg    <= acc_reg + partial;
            mcand_reg  <= mcand_reg << MUL_BITS;
            mplier_reg <= mplier_reg >> MUL_BITS;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (cnt_reg == MUL_LAST)
              state_reg <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (annul_i) begin
            state_reg <= ST_IDLE;
          end else begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == DIV_LAST)
              state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          // An annulled result is dropped, leaving the previous one on result_o.
          if (!annul_i)
            result_reg <= fixed;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_reg != ST_IDLE);
  assign stallreq_o = accept | (state_reg == ST_MUL) | (state_reg == ST_DIV);
  assign ready_o    = (state_reg == ST_DONE) & ~annul_i;
  assign result_o   = ready_o ? fixed : result_reg;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed vector table, randomized ops
// against an arithmetic reference model, and hand sequences for annul/start/reset.
module tb_muldiv_iter;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        stallreq_o;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_iter #(
    .DATA_W   (32),
    .MUL_BITS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .stallreq_o (stallreq_o),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operand values.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = {32'd0, a} * {32'd0, b};
      2'b01: p = 64'(sa * sb);
      2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return 9;
    return (b == 0) ? 1 : 33;
  endfunction

  // Drives one start and waits (bounded) for ready_o; cycle 0 is the start cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output bit stall_bad);
    stall_bad = 1'b0;
    lat       = -1;
    res       = '0;
    @(negedge clk);
    start_i   = 1'b1;
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (ready_o) begin
        lat = c;
        res = result_o;
        if (stallreq_o) stall_bad = 1'b1;
        break;
      end
      if (!stallreq_o) stall_bad = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    start_i = 1'b0;
  endtask

  task automatic apply_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    logic [63:0] res;
    int          lat;
    bit          stall_bad;
    run_op(op, a, b, res, lat, stall_bad);
    $display("%s op=%0d a=%h b=%h -> result=%h lat=%0d (expect %h lat %0d)",
             tag, op, a, b, res, lat, exp_res, exp_lat);
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stallreq"}, 64'(stall_bad), 64'(0));
    @(negedge clk);
    #1;
    check({tag, " held result"}, result_o, exp_res);
    check({tag, " busy after"}, 64'(busy_o), 64'(0));
  endtask

  initial begin
    logic [63:0] prev;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit          saw_ready;

    vecs[0] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 9};
    vecs[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 9};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 9};
    vecs[3] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
    vecs[5] = '{2'b10, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF, 1};
    vecs[6] = '{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, 1};
    vecs[7] = '{2'b10, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 33};
    vecs[8] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[9] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 9};

    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset: busy=%0b ready=%0b stall=%0b result=%h", busy_o, ready_o, stallreq_o, result_o);
    check("reset busy", 64'(busy_o), 64'(0));
    check("reset ready", 64'(ready_o), 64'(0));
    check("reset stallreq", 64'(stallreq_o), 64'(0));
    check("reset result", result_o, 64'(0));

    for (int i = 0; i < 10; i++)
      apply_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].exp_res, vecs[i].exp_lat);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      apply_and_check($sformatf("rnd%0d", i), rop, ra, rb, ref_model(rop, ra, rb), ref_lat(rop, rb));
    end

    // Annul mid-divide: no ready pulse, previous result kept, then a clean MULTU.
    prev = result_o;
    saw_ready = 1'b0;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) annul_i = 1'b1;
      #1;
      if (ready_o) saw_ready = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    annul_i = 1'b0;
    #1;
    $display("annul div: busy=%0b result=%h ready_seen=%0b", busy_o, result_o, saw_ready);
    check("annul busy", 64'(busy_o), 64'(0));
    check("annul result", result_o, prev);
    check("annul ready", 64'(saw_ready), 64'(0));
    apply_and_check("post-annul", 2'b00, 32'd2, 32'd3, 64'd6, 9);

    // Annul in the DONE cycle of a divide-by-zero drops the result.
    prev = result_o;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd55; opdata2_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b1;
    #1;
    $display("annul done: ready=%0b result=%h", ready_o, result_o);
    check("annul-done ready", 64'(ready_o), 64'(0));
    check("annul-done result", result_o, prev);
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    check("annul-done held", result_o, prev);
    check("annul-done busy", 64'(busy_o), 64'(0));

    // Start together with annul in IDLE is refused.
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b00; opdata1_i = 32'd9; opdata2_i = 32'd9;
    #1;
    check("start+annul stall", 64'(stallreq_o), 64'(0));
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    #1;
    $display("start+annul: busy=%0b", busy_o);
    check("start+annul busy", 64'(busy_o), 64'(0));

    // A second start during a MULT is ignored.
    begin
      int lat;
      logic [63:0] res;
      lat = -1; res = '0;
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; opdata1_i = 32'hFFFF_FFFD; opdata2_i = 32'd5;
      for (int c = 0; c < 40; c++) begin
        start_i = (c == 0 || c == 4);
        if (c == 4) begin
          op_i = 2'b00; opdata1_i = 32'd7; opdata2_i = 32'd7;
        end
        #1;
        if (ready_o) begin
          lat = c; res = result_o;
          break;
        end
        @(negedge clk);
      end
      start_i = 1'b0;
      $display("restart ignored: result=%h lat=%0d", res, lat);
      check("restart result", res, 64'hFFFF_FFFF_FFFF_FFF1);
      check("restart latency", 64'(lat), 64'(9));
    end

    // Synchronous reset mid-divide clears everything without a ready pulse.
    saw_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) rst = 1'b1;
      #1;
      if (ready_o) saw_ready = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b0;
    #1;
    $display("reset mid-op: busy=%0b ready=%0b stall=%0b result=%h",
             busy_o, ready_o, stallreq_o, result_o);
    check("midrst busy", 64'(busy_o), 64'(0));
    check("midrst stall", 64'(stallreq_o), 64'(0));
    check("midrst result", result_o, 64'(0));
    for (int c = 0; c < 40; c++) begin
      if (ready_o) saw_ready = 1'b1;
      @(negedge clk);
      #1;
    end
    check("midrst no ready", 64'(saw_ready), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
